// File: rtl/router_fsm_n.sv
// rtl/router_fsm_n.sv - control FSM for a parametrised 1xN packet router
// Decodes header address, sequences writes, handles full stalls, busy-wait timeout and illegal-address drop.
module router_fsm_n #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [NUM_CH-1:0] dest_sel,
  output logic              drop_state,
  output logic              addr_err,
  output logic              wait_timeout
);

  typedef enum logic [3:0] {
    S_DA, S_LFD, S_LD, S_LP, S_FFS, S_LAF, S_WTE, S_CPE, S_DROP
  } state_t;

  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [ADDR_W:0]  NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

  state_t            state, next_state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              addr_illegal;
  logic              sel_soft_reset;
  logic              sel_empty;
  logic              new_empty;
  logic              addr_hit;
  logic              timeout_hit;

  assign addr_illegal   = ({1'b0, data_in} >= NUM_CH_EXT);
  assign sel_soft_reset = soft_reset[cur_addr];
  assign sel_empty      = fifo_empty[cur_addr];
  assign new_empty      = fifo_empty[data_in];

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_DA;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_DA: begin
        if (pkt_valid) begin
          if (addr_illegal)   next_state = S_DROP;
          else if (new_empty) next_state = S_LFD;
          else                next_state = S_WTE;
        end
      end
      S_LFD: next_state = S_LD;
      S_LD: begin
        if (fifo_full)       next_state = S_FFS;
        else if (!pkt_valid) next_state = S_LP;
      end
      S_FFS: if (!fifo_full) next_state = S_LAF;
      S_LAF: begin
        if (parity_done)        next_state = S_DA;
        else if (low_pkt_valid) next_state = S_LP;
        else                    next_state = S_LD;
      end
      S_LP:  next_state = S_CPE;
      S_CPE: next_state = fifo_full ? S_FFS : S_DA;
      S_WTE: begin
        if (sel_empty)                 next_state = S_LFD;
        else if (wait_cnt == CNT_LAST) next_state = S_DROP;
      end
      S_DROP: if (!pkt_valid) next_state = S_DA;
      default: next_state = S_DA;
    endcase
    // A read-timeout on the owning channel aborts any in-flight packet.
    if (state != S_DA && state != S_DROP && sel_soft_reset) next_state = S_DA;
  end

  assign addr_hit    = (state == S_DA)  && (next_state == S_DROP);
  assign timeout_hit = (state == S_WTE) && (next_state == S_DROP);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cur_addr     <= '0;
      dest_sel     <= '0;
      wait_cnt     <= '0;
      addr_err     <= 1'b0;
      wait_timeout <= 1'b0;
    end else begin
      addr_err     <= addr_hit;
      wait_timeout <= timeout_hit;
      if (state == S_DA && pkt_valid && !addr_illegal) begin
        cur_addr <= data_in;
        dest_sel <= NUM_CH'(1) << data_in;
      end else if (next_state == S_DA || next_state == S_DROP) begin
        dest_sel <= '0;
      end
      if (state == S_WTE) wait_cnt <= wait_cnt + 1'b1;
      else                wait_cnt <= '0;
    end
  end

  assign detect_add    = (state == S_DA);
  assign lfd_state     = (state == S_LFD);
  assign ld_state      = (state == S_LD);
  assign laf_state     = (state == S_LAF);
  assign full_state    = (state == S_FFS);
  assign rst_int_reg   = (state == S_CPE);
  assign drop_state    = (state == S_DROP);
  assign write_enb_reg = (state == S_LD) || (state == S_LP) || (state == S_LAF);
  assign busy          = (state == S_LFD) || (state == S_LP) || (state == S_FFS) ||
                         (state == S_LAF) || (state == S_WTE) || (state == S_CPE);

endmodule

// File: tb/tb_router_fsm_n.sv
// tb/tb_router_fsm_n.sv - directed self-checking bench for router_fsm_n
// A second instance with WAIT_TIMEOUT=4 shares the stimulus for the timeout case.
module tb_router_fsm_n;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;

  logic       da, lfd, ld, laf, ffs, we, rst_int, bsy, drp, aerr, wto;
  logic [2:0] dsel;
  logic       da4, lfd4, ld4, laf4, ffs4, we4, rst_int4, bsy4, drp4, aerr4, wto4;
  logic [2:0] dsel4;
  logic [8:0] flags, flags4;

  int total = 0;
  int bad   = 0;

  // {detect_add, lfd, ld, laf, full, rst_int, drop, write_enb, busy}
  localparam logic [8:0] F_DA   = 9'b100000000;
  localparam logic [8:0] F_LFD  = 9'b010000001;
  localparam logic [8:0] F_LD   = 9'b001000010;
  localparam logic [8:0] F_LAF  = 9'b000100011;
  localparam logic [8:0] F_FFS  = 9'b000010001;
  localparam logic [8:0] F_CPE  = 9'b000001001;
  localparam logic [8:0] F_DROP = 9'b000000100;
  localparam logic [8:0] F_LP   = 9'b000000011;
  localparam logic [8:0] F_WTE  = 9'b000000001;

  router_fsm_n #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(64)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .detect_add(da), .lfd_state(lfd), .ld_state(ld), .laf_state(laf), .full_state(ffs),
    .write_enb_reg(we), .rst_int_reg(rst_int), .busy(bsy), .dest_sel(dsel),
    .drop_state(drp), .addr_err(aerr), .wait_timeout(wto)
  );

  router_fsm_n #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) dut4 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .detect_add(da4), .lfd_state(lfd4), .ld_state(ld4), .laf_state(laf4), .full_state(ffs4),
    .write_enb_reg(we4), .rst_int_reg(rst_int4), .busy(bsy4), .dest_sel(dsel4),
    .drop_state(drp4), .addr_err(aerr4), .wait_timeout(wto4)
  );

  assign flags  = {da,  lfd,  ld,  laf,  ffs,  rst_int,  drp,  we,  bsy};
  assign flags4 = {da4, lfd4, ld4, laf4, ffs4, rst_int4, drp4, we4, bsy4};

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 1'b0; fifo_empty = 3'b111; soft_reset = 3'b000;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_flags", 32'(flags), 32'(F_DA));
    check("rst_dsel", 32'(dsel), 32'd0);
    check("rst_pulses", {30'd0, aerr, wto}, 32'd0);

    // normal packet to channel 1
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); check("n_lfd", 32'(flags), 32'(F_LFD));
    check("n_dsel", 32'(dsel), 32'b010);
    step(); check("n_ld1", 32'(flags), 32'(F_LD));
    step(); check("n_ld2", 32'(flags), 32'(F_LD));
    pkt_valid = 1'b0;
    step(); check("n_lp", 32'(flags), 32'(F_LP));
    step(); check("n_cpe", 32'(flags), 32'(F_CPE));
    step(); check("n_da", 32'(flags), 32'(F_DA));
    check("n_dsel_clr", 32'(dsel), 32'd0);

    // full stall then low_pkt_valid
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); step(); check("f_ld", 32'(flags), 32'(F_LD));
    fifo_full = 1'b1;
    step(); check("f_ffs1", 32'(flags), 32'(F_FFS));
    step(); check("f_ffs2", 32'(flags), 32'(F_FFS));
    fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    step(); check("f_laf", 32'(flags), 32'(F_LAF));
    step(); check("f_lp", 32'(flags), 32'(F_LP));
    low_pkt_valid = 1'b0;
    step(); check("f_cpe", 32'(flags), 32'(F_CPE));
    step(); check("f_da", 32'(flags), 32'(F_DA));

    // busy destination, released after 5 cycles
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    for (int i = 0; i < 5; i++) begin
      step(); check($sformatf("b_wte%0d", i), 32'(flags), 32'(F_WTE));
    end
    check("b_dsel", 32'(dsel), 32'b100);
    fifo_empty = 3'b111;
    step(); check("b_lfd", 32'(flags), 32'(F_LFD));
    check("b_noto", 32'(wto), 32'd0);

    // timeout on the WAIT_TIMEOUT=4 instance
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b110;
    for (int i = 0; i < 4; i++) begin
      step(); check($sformatf("t_wte%0d", i), 32'(flags4), 32'(F_WTE));
      check($sformatf("t_noto%0d", i), 32'(wto4), 32'd0);
    end
    step(); check("t_drop", 32'(flags4), 32'(F_DROP));
    check("t_pulse", 32'(wto4), 32'd1);
    check("t_dsel", 32'(dsel4), 32'd0);
    check("t_long_wte", 32'(flags), 32'(F_WTE));
    step(); check("t_drop2", 32'(flags4), 32'(F_DROP));
    check("t_pulse_end", 32'(wto4), 32'd0);
    pkt_valid = 1'b0;
    step(); check("t_da", 32'(flags4), 32'(F_DA));

    // illegal address
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd3;
    step(); check("i_drop", 32'(flags), 32'(F_DROP));
    check("i_aerr", 32'(aerr), 32'd1);
    check("i_dsel", 32'(dsel), 32'd0);
    step(); check("i_aerr_end", 32'(aerr), 32'd0);
    check("i_drop2", 32'(flags), 32'(F_DROP));
    pkt_valid = 1'b0;
    step(); check("i_da", 32'(flags), 32'(F_DA));

    // soft reset on other vs own channel
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); step(); check("s_ld", 32'(flags), 32'(F_LD));
    soft_reset = 3'b100;
    step(); check("s_ignored", 32'(flags), 32'(F_LD));
    soft_reset = 3'b010;
    step(); check("s_da", 32'(flags), 32'(F_DA));
    check("s_dsel", 32'(dsel), 32'd0);
    soft_reset = 3'b000;

    // hard reset while stalled
    step(); step(); fifo_full = 1'b1;
    step(); check("r_ffs", 32'(flags), 32'(F_FFS));
    resetn = 1'b0;
    step(); check("r_da", 32'(flags), 32'(F_DA));
    check("r_dsel", 32'(dsel), 32'd0);
    check("r_pulses", {30'd0, aerr, wto}, 32'd0);
    resetn = 1'b1; fifo_full = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
